// File: rtl/apb_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_pkg
// Description : Register indices, register count and trigger-type encoding
//               shared by the APB GPIO register block.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_gpio_pkg;

    // Word-indexed register map
    localparam logic [31:0] c_REG_MODE      = 32'd0;
    localparam logic [31:0] c_REG_DIRECTION = 32'd1;
    localparam logic [31:0] c_REG_OUTPUT    = 32'd2;
    localparam logic [31:0] c_REG_INPUT     = 32'd3;
    localparam logic [31:0] c_REG_TR_TYPE   = 32'd4;
    localparam logic [31:0] c_REG_TR_LVL0   = 32'd5;
    localparam logic [31:0] c_REG_TR_LVL1   = 32'd6;
    localparam logic [31:0] c_REG_TR_STAT   = 32'd7;
    localparam logic [31:0] c_REG_IRQ_EN    = 32'd8;

    localparam logic [31:0] c_NUM_REGS      = 32'd9;

    // Per-pin TR_TYPE bit encoding
    localparam logic c_TRIG_LEVEL = 1'b0;
    localparam logic c_TRIG_EDGE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gpio_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_sync
// Description : STAGES-deep synchronizer for asynchronous pad inputs plus one
//               extra delay flop, giving the current (o_sync) and previous
//               (o_prev) synchronized value of every pin. STAGES must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_sync
    import apb_gpio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_prev
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;
    logic [WIDTH-1:0]             r_prev;

    // Shift pad values through the synchronizer chain and keep one extra delay
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_chain <= '0;
            r_prev  <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_pins};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_prev = r_prev;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_slave
// Description : APB3 GPIO register block: direction, push-pull/open-drain
//               output drive, synchronized inputs and per-pin level/edge
//               interrupt detection with a single registered irq_o.
//               Build macro GPIO_OPEN_DRAIN_EN enables the MODE register;
//               without it MODE reads 0 and every pin is push-pull.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_PINS  = 32,
    parameter int PADDR_SIZE = 4,
    parameter int STAGES     = 2
) (
    input  logic                   CLK,
    input  logic                   HRESETn,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic [PADDR_SIZE-1:0]  PADDR,
    input  logic                   PWRITE,
    input  logic [GPIO_PINS-1:0]   PWDATA,
    input  logic [GPIO_PINS/8-1:0] PSTRB,
    output logic                   PREADY,
    output logic [GPIO_PINS-1:0]   PRDATA,
    output logic                   PSLVERR,
    output logic                   irq_o,
    input  logic [GPIO_PINS-1:0]   gpio_i,
    output logic [GPIO_PINS-1:0]   gpio_o,
    output logic [GPIO_PINS-1:0]   gpio_oe
);

    logic [GPIO_PINS-1:0] r_dir, r_out, r_tr_type, r_lvl0, r_lvl1, r_tr_stat, r_irq_en;
    logic                 r_irq;
    logic [GPIO_PINS-1:0] w_mode, w_bmask, w_new, w_clr, w_trig, w_sync, w_prev, w_rdata;
    logic [31:0]          w_idx;
    logic                 w_addr_valid, w_access, w_wr_en;

    gpio_input_sync #(
        .WIDTH  (GPIO_PINS),
        .STAGES (STAGES)
    ) u_sync (
        .CLK     (CLK),
        .HRESETn (HRESETn),
        .i_pins  (gpio_i),
        .o_sync  (w_sync),
        .o_prev  (w_prev)
    );

    // Addresses are small word indices; zero-extend for comparison with the map
    assign w_idx        = 32'(PADDR);
    assign w_addr_valid = (w_idx < c_NUM_REGS);
    assign w_access     = PSEL & PENABLE;
    assign w_wr_en      = w_access & PWRITE & w_addr_valid;

    for (genvar i = 0; i < GPIO_PINS / 8; i++) begin : g_lane
        assign w_bmask[8*i +: 8] = {8{PSTRB[i]}};
    end

    // Byte-lane merged write data is only meaningful for the addressed register
    always_comb begin
        w_new = PWDATA & w_bmask;
        case (w_idx)
            c_REG_DIRECTION: w_new = (r_dir     & ~w_bmask) | (PWDATA & w_bmask);
            c_REG_OUTPUT:    w_new = (r_out     & ~w_bmask) | (PWDATA & w_bmask);
            c_REG_TR_TYPE:   w_new = (r_tr_type & ~w_bmask) | (PWDATA & w_bmask);
            c_REG_TR_LVL0:   w_new = (r_lvl0    & ~w_bmask) | (PWDATA & w_bmask);
            c_REG_TR_LVL1:   w_new = (r_lvl1    & ~w_bmask) | (PWDATA & w_bmask);
            c_REG_IRQ_EN:    w_new = (r_irq_en  & ~w_bmask) | (PWDATA & w_bmask);
            default:         w_new = PWDATA & w_bmask;
        endcase
    end

    assign w_clr = (w_wr_en && (w_idx == c_REG_TR_STAT)) ? (PWDATA & w_bmask) : '0;

    // Per-pin trigger: level or edge condition selected by TR_TYPE
    for (genvar i = 0; i < GPIO_PINS; i++) begin : g_pin
        logic w_lvl_hit, w_edge_hit;
        assign w_lvl_hit  = (r_lvl0[i] & ~w_sync[i]) | (r_lvl1[i] & w_sync[i]);
        assign w_edge_hit = (r_lvl0[i] & w_prev[i] & ~w_sync[i]) |
                            (r_lvl1[i] & ~w_prev[i] & w_sync[i]);
        assign w_trig[i]  = (r_tr_type[i] == c_TRIG_EDGE) ? w_edge_hit : w_lvl_hit;
    end

`ifdef GPIO_OPEN_DRAIN_EN
    logic [GPIO_PINS-1:0] r_mode;

    // MODE register: 1 selects open-drain drive for that pin
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mode <= '0;
        end else if (w_wr_en && (w_idx == c_REG_MODE)) begin
            r_mode <= (r_mode & ~w_bmask) | (PWDATA & w_bmask);
        end
    end

    assign w_mode = r_mode;
`else
    assign w_mode = '0;
`endif

    // Register file; a TR_STAT set in the same cycle as its W1C clear wins
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_tr_type <= '0;
            r_lvl0    <= '0;
            r_lvl1    <= '0;
            r_tr_stat <= '0;
            r_irq_en  <= '0;
        end else begin
            r_tr_stat <= (r_tr_stat & ~w_clr) | w_trig;
            if (w_wr_en) begin
                case (w_idx)
                    c_REG_DIRECTION: r_dir     <= w_new;
                    c_REG_OUTPUT:    r_out     <= w_new;
                    c_REG_TR_TYPE:   r_tr_type <= w_new;
                    c_REG_TR_LVL0:   r_lvl0    <= w_new;
                    c_REG_TR_LVL1:   r_lvl1    <= w_new;
                    c_REG_IRQ_EN:    r_irq_en  <= w_new;
                    default:         ;
                endcase
            end
        end
    end

    // Interrupt output registered from enabled sticky status
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_tr_stat & r_irq_en);
        end
    end

    // Read mux of the addressed register; unmapped indices read 0
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_REG_MODE:      w_rdata = w_mode;
            c_REG_DIRECTION: w_rdata = r_dir;
            c_REG_OUTPUT:    w_rdata = r_out;
            c_REG_INPUT:     w_rdata = w_sync;
            c_REG_TR_TYPE:   w_rdata = r_tr_type;
            c_REG_TR_LVL0:   w_rdata = r_lvl0;
            c_REG_TR_LVL1:   w_rdata = r_lvl1;
            c_REG_TR_STAT:   w_rdata = r_tr_stat;
            c_REG_IRQ_EN:    w_rdata = r_irq_en;
            default:         w_rdata = '0;
        endcase
    end

    assign PRDATA  = (PSEL & ~PWRITE) ? w_rdata : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_addr_valid;
    assign irq_o   = r_irq;

    // Open-drain pins never drive high: they release instead
    assign gpio_o  = r_out & ~w_mode;
    assign gpio_oe = r_dir & ~(w_mode & r_out);

endmodule
`default_nettype wire
